// File: rtl/bnn_pkg.sv
// Shared widths, FSM states and pipeline tag for the binary-NN layer engine.
package bnn_pkg;

   localparam int LANES        = 16;
   localparam int IN_WORDS_MAX = 64;
   localparam int OUT_MAX      = 1024;
   localparam int W_ADDR_LEN   = 16;
   localparam int X_ADDR_LEN   = $clog2(IN_WORDS_MAX);
   localparam int Y_ADDR_LEN   = $clog2(OUT_MAX);
   localparam int ACC_W        = $clog2(IN_WORDS_MAX * LANES + 1);
   localparam int POP_W        = $clog2(LANES + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FIN
   } state_t;

   typedef struct packed {
      logic                  first;
      logic                  last;
      logic [Y_ADDR_LEN-1:0] n;
   } tag_t;

endpackage

// File: rtl/bnn_xnor_popcnt.sv
// Combinational LANES-wide XNOR followed by a population count.
module bnn_xnor_popcnt
   import bnn_pkg::*;
(
   input  logic [LANES-1:0] w,
   input  logic [LANES-1:0] x,
   output logic [POP_W-1:0] pop
);

   logic [LANES-1:0] xn;

   assign xn = ~(w ^ x);

   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) begin
         pop = pop + POP_W'(xn[i]);
      end
   end

endmodule

// File: rtl/bnn_layer_engine.sv
// Fully-connected binary layer: streams weight/activation words, accumulates
// XNOR-popcount per neuron and writes the sign bit plus raw score.
module bnn_layer_engine
   import bnn_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [X_ADDR_LEN:0]   cfg_in_words,
   input  logic [Y_ADDR_LEN:0]   cfg_out_neurons,
   output logic                  busy,
   output logic                  done,
   output logic                  w_en,
   output logic [W_ADDR_LEN-1:0] w_addr,
   input  logic [LANES-1:0]      w_rdata,
   output logic                  x_en,
   output logic [X_ADDR_LEN-1:0] x_addr,
   input  logic [LANES-1:0]      x_rdata,
   output logic                  y_we,
   output logic [Y_ADDR_LEN-1:0] y_addr,
   output logic                  y_bit,
   output logic [ACC_W-1:0]      y_score
);

   state_t state, state_nx;

   logic [X_ADDR_LEN:0]   in_words, in_clamp;
   logic [Y_ADDR_LEN:0]   out_neurons, out_clamp;
   logic [X_ADDR_LEN-1:0] k;
   logic [Y_ADDR_LEN-1:0] n;
   logic [W_ADDR_LEN-1:0] w_cnt;
   logic                  drain_cnt;
   logic                  last_word, last_neuron, cfg_zero;

   tag_t             tag_q;
   logic             vld_q;
   logic [POP_W-1:0] pop;
   logic [ACC_W-1:0] acc, acc_nx;
   logic [ACC_W:0]   thr;

   assign in_clamp = (cfg_in_words > (X_ADDR_LEN+1)'(IN_WORDS_MAX))
                   ? (X_ADDR_LEN+1)'(IN_WORDS_MAX) : cfg_in_words;
   assign out_clamp = (cfg_out_neurons > (Y_ADDR_LEN+1)'(OUT_MAX))
                    ? (Y_ADDR_LEN+1)'(OUT_MAX) : cfg_out_neurons;
   assign cfg_zero = (cfg_in_words == '0) || (cfg_out_neurons == '0);

   assign last_word   = ({1'b0, k} == in_words - (X_ADDR_LEN+1)'(1));
   assign last_neuron = ({1'b0, n} == out_neurons - (Y_ADDR_LEN+1)'(1));

   assign busy   = (state != IDLE);
   assign done   = (state == FIN);
   assign w_en   = (state == ISSUE);
   assign x_en   = (state == ISSUE);
   assign w_addr = w_cnt;
   assign x_addr = k;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = cfg_zero ? FIN : ISSUE;
         ISSUE:   if (last_word && last_neuron) state_nx = DRAIN;
         DRAIN:   if (drain_cnt) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // w_cnt runs linearly across the whole layer, avoiding an n*in_words multiply
   always_ff @(posedge clk) begin
      if (rst) begin
         in_words    <= '0;
         out_neurons <= '0;
         k           <= '0;
         n           <= '0;
         w_cnt       <= '0;
         drain_cnt   <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            in_words    <= in_clamp;
            out_neurons <= out_clamp;
         end
         if (state == ISSUE) begin
            w_cnt <= (last_word && last_neuron)
                   ? '0 : w_cnt + W_ADDR_LEN'(1);
            k     <= last_word ? '0 : k + X_ADDR_LEN'(1);
            if (last_word)
               n <= last_neuron ? '0 : n + Y_ADDR_LEN'(1);
         end
         drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      end
   end

   bnn_xnor_popcnt u_pop (
      .w   (w_rdata),
      .x   (x_rdata),
      .pop (pop)
   );

   assign acc_nx = tag_q.first ? ACC_W'(pop) : acc + ACC_W'(pop);
   // Tie (score exactly half) counts as non-negative
   assign thr = (ACC_W+1)'(in_words) * (ACC_W+1)'(LANES);

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= 1'b0;
         tag_q   <= '0;
         acc     <= '0;
         y_we    <= 1'b0;
         y_addr  <= '0;
         y_bit   <= 1'b0;
         y_score <= '0;
      end else begin
         vld_q       <= (state == ISSUE);
         tag_q.first <= (k == '0);
         tag_q.last  <= last_word;
         tag_q.n     <= n;
         y_we        <= vld_q && tag_q.last;
         if (vld_q) acc <= acc_nx;
         if (vld_q && tag_q.last) begin
            y_addr  <= tag_q.n;
            y_score <= acc_nx;
            y_bit   <= ({acc_nx, 1'b0} >= thr);
         end
      end
   end

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Scoreboard bench for bnn_layer_engine with 1-cycle-latency RAM models.
module tb_bnn_layer_engine;
   import bnn_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  start = 1'b0;
   logic [X_ADDR_LEN:0]   cfg_in_words = '0;
   logic [Y_ADDR_LEN:0]   cfg_out_neurons = '0;
   logic                  busy, done, w_en, x_en, y_we, y_bit;
   logic [W_ADDR_LEN-1:0] w_addr;
   logic [X_ADDR_LEN-1:0] x_addr;
   logic [Y_ADDR_LEN-1:0] y_addr;
   logic [ACC_W-1:0]      y_score;
   logic [LANES-1:0]      w_rdata = '0;
   logic [LANES-1:0]      x_rdata = '0;

   logic [15:0] w_mem [0:255];
   logic [15:0] x_mem [0:63];

   typedef struct {
      int addr;
      int bt;
      int score;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int exp_in = 1;
   int epoch = 0;
   int seen_epoch = 0;
   int aw = 0;
   int ak = 0;
   int last_we = 0;
   bit rst_chk = 0;
   bit quiet = 0;
   bit fin_req = 0;
   bit mon_done = 0;
   bit we_flag = 0;

   always #5 clk = ~clk;

   bnn_layer_engine dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .cfg_in_words    (cfg_in_words),
      .cfg_out_neurons (cfg_out_neurons),
      .busy            (busy),
      .done            (done),
      .w_en            (w_en),
      .w_addr          (w_addr),
      .w_rdata         (w_rdata),
      .x_en            (x_en),
      .x_addr          (x_addr),
      .x_rdata         (x_rdata),
      .y_we            (y_we),
      .y_addr          (y_addr),
      .y_bit           (y_bit),
      .y_score         (y_score)
   );

   always @(posedge clk) begin
      if (w_en) w_rdata <= w_mem[w_addr[7:0]];
      if (x_en) x_rdata <= x_mem[x_addr];
   end

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         we_flag = 0;
         if (rst_chk)
            chk("reset_outputs",
                {busy, done, w_en, x_en, y_we, y_bit, y_addr, y_score}, 0);
      end else begin
         if (quiet) chk("quiet_enables", {w_en, x_en, y_we}, 0);
         if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            aw = 0;
            ak = 0;
         end
         if (w_en) begin
            chk("w_addr", w_addr, aw);
            chk("x_addr", x_addr, ak);
            chk("x_en", x_en, 1);
            aw++;
            ak = (ak + 1 == exp_in) ? 0 : ak + 1;
         end
         if (y_we) begin
            if (sb.size() == 0) begin
               chk("unexpected_y_we", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("y_addr", y_addr, e.addr);
               chk("y_bit", y_bit, e.bt);
               chk("y_score", y_score, e.score);
            end
            if (we_flag) chk("y_we_spacing", cyc - last_we, exp_in);
            we_flag = 1;
            last_we = cyc;
         end
         if (done) begin
            if (we_flag) chk("done_after_y_we", cyc - last_we, 1);
            we_flag = 0;
         end
         if (fin_req && !mon_done) begin
            chk("sb_empty", sb.size(), 0);
            mon_done = 1;
         end
      end
   end

   task automatic pulse(input int iw, input int ow);
      @(posedge clk);
      #1;
      cfg_in_words    = (X_ADDR_LEN+1)'(iw);
      cfg_out_neurons = (Y_ADDR_LEN+1)'(ow);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic begin_layer(input int iw, input int ow, input int eff_in);
      exp_in = eff_in;
      epoch++;
      pulse(iw, ow);
   endtask

   task automatic push_exp(input int a, input int b, input int s);
      sb.push_back('{addr: a, bt: b, score: s});
   endtask

   task automatic push_model(input int in, input int out);
      logic [15:0] xn;
      int s;
      for (int j = 0; j < out; j++) begin
         s = 0;
         for (int i = 0; i < in; i++) begin
            xn = ~(w_mem[j*in + i] ^ x_mem[i]);
            s += $countones(xn);
         end
         push_exp(j, (2 * s >= in * 16) ? 1 : 0, s);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < 256; i++) w_mem[i] = 16'($urandom);
      for (int i = 0; i < 64; i++) x_mem[i] = 16'($urandom);
   endtask

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (done) break;
      end
      if (i == 5000) begin
         $display("FAIL timeout_%s: got no done want done", name);
         $fatal(1, "no done pulse");
      end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) w_mem[i] = '0;
      for (int i = 0; i < 64; i++) x_mem[i] = '0;

      @(posedge clk);
      #1 rst_chk = 1;
      repeat (2) @(posedge clk);
      #1;
      rst_chk = 0;
      rst = 1'b0;

      // one word, all lanes agree
      w_mem[0] = 16'hFFFF;
      x_mem[0] = 16'hFFFF;
      push_exp(0, 1, 16);
      begin_layer(1, 1, 1);
      wait_done("single");

      // tie goes to 1, one below tie goes to 0
      w_mem[0] = 16'h00FF;
      w_mem[1] = 16'h007F;
      x_mem[0] = 16'hFFFF;
      push_exp(0, 1, 8);
      push_exp(1, 0, 7);
      begin_layer(1, 2, 1);
      wait_done("tie");

      fill_random();
      push_model(49, 4);
      begin_layer(49, 4, 49);
      wait_done("mnist");

      quiet = 1;
      begin_layer(0, 3, 1);
      wait_done("zero_in");
      begin_layer(5, 0, 5);
      wait_done("zero_out");
      #1 quiet = 0;

      fill_random();
      push_model(64, 1);
      begin_layer(100, 1, 64);
      wait_done("clamp");

      // reset in the middle of neuron 1
      fill_random();
      push_model(49, 4);
      begin_layer(49, 4, 49);
      begin
         int i;
         for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (w_en && w_addr == 16'd69) break;
         end
         if (i == 1000) begin
            $display("FAIL timeout_mid_reset: got no word 69 want word 69");
            $fatal(1, "word 69 never issued");
         end
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      w_mem[0] = 16'hF0F0;
      w_mem[1] = 16'hFFFF;
      x_mem[0] = 16'hF0F0;
      x_mem[1] = 16'h0000;
      push_exp(0, 1, 16);
      begin_layer(2, 1, 2);
      wait_done("after_reset");

      // second start while busy must be ignored
      fill_random();
      push_model(3, 2);
      begin_layer(3, 2, 3);
      pulse(1, 5);
      wait_done("busy_start");

      fin_req = 1;
      begin
         int i;
         for (i = 0; i < 20; i++) begin
            @(posedge clk);
            if (mon_done) break;
         end
         if (!mon_done) begin
            $display("FAIL monitor_final: got idle want finished");
            $fatal(1, "monitor stalled");
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
